// File: rtl/shady_pong_pkg.sv
// ============================================================================
// Module      : shady_pong_pkg
// Description : Shared constants and types for the Pong input path: button
//               channel indices and the per-channel move FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shady_pong_pkg;

    // Channel assignment of the four game buttons on btn_raw / ui_in
    localparam int BTN_P2_DOWN = 0;
    localparam int BTN_P2_UP   = 1;
    localparam int BTN_P1_DOWN = 2;
    localparam int BTN_P1_UP   = 3;

    // Move FSM: IDLE (released), DELAY (waiting for first repeat), REPEAT
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } move_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ============================================================================
// Module      : btn_channel
// Description : One button channel: synchroniser, counter debouncer,
//               press/release pulse generator and frame-locked move FSM
//               with auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_channel
    import shady_pong_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16384,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic frame_tick,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_move
);

    localparam int c_dcnt_w = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(DEBOUNCE_CYCLES - 1);

    // Frame counter must hold the larger of the two repeat limits
    localparam int c_fcnt_max = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                ((REPEAT_DELAY > 2) ? REPEAT_DELAY : 2) :
                                ((REPEAT_PERIOD > 2) ? REPEAT_PERIOD : 2);
    localparam int c_fcnt_w   = $clog2(c_fcnt_max);
    localparam logic [c_fcnt_w-1:0] c_delay_last  = c_fcnt_w'(REPEAT_DELAY - 1);
    localparam logic [c_fcnt_w-1:0] c_period_last =
        c_fcnt_w'((REPEAT_PERIOD > 0) ? (REPEAT_PERIOD - 1) : 0);
    localparam logic c_repeat_en = (REPEAT_PERIOD != 0);

    // XOR with this turns the pad level into "1 = pressed"
    localparam logic c_norm = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_dcnt_w-1:0]    r_dcnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic [c_fcnt_w-1:0]    r_fcnt;
    logic                   r_move;
    move_state_t            r_state;

    logic w_sync;
    logic w_differ;
    logic w_settle;
    logic w_rise;
    logic w_fall;
    logic w_tick;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_differ = (w_sync != r_level);
    assign w_settle = w_differ && (r_dcnt == c_dcnt_last);
    assign w_rise   = w_settle & ~r_level;
    assign w_fall   = w_settle &  r_level;
    // A tick landing in the press-pulse cycle belongs to the press, not the timer
    assign w_tick   = frame_tick & ~r_press;

    // Normalise polarity, then shift through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw ^ c_norm};
        end
    end

    // Debounce: level follows sync only after DEBOUNCE_CYCLES of disagreement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
            if (w_settle) begin
                r_level <= ~r_level;
                r_dcnt  <= '0;
            end else if (w_differ) begin
                r_dcnt  <= r_dcnt + c_dcnt_w'(1);
            end else begin
                r_dcnt  <= '0;
            end
        end
    end

    // Move FSM: pulse on press, then after REPEAT_DELAY and every REPEAT_PERIOD ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_fcnt  <= '0;
            r_move  <= 1'b0;
        end else begin
            r_move <= 1'b0;
            if (w_fall) begin
                r_state <= IDLE;
                r_fcnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_move  <= 1'b1;
                            r_state <= DELAY;
                            r_fcnt  <= '0;
                        end
                    end
                    DELAY: begin
                        // With repeat disabled DELAY is a pure hold state
                        if (w_tick && c_repeat_en) begin
                            if (r_fcnt == c_delay_last) begin
                                r_move  <= 1'b1;
                                r_fcnt  <= '0;
                                r_state <= REPEAT;
                            end else begin
                                r_fcnt  <= r_fcnt + c_fcnt_w'(1);
                            end
                        end
                    end
                    REPEAT: begin
                        if (w_tick) begin
                            if (r_fcnt == c_period_last) begin
                                r_move <= 1'b1;
                                r_fcnt <= '0;
                            end else begin
                                r_fcnt <= r_fcnt + c_fcnt_w'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_fcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_move    = r_move;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module      : btn_conditioner
// Description : Button input conditioning for the Pong core. Instantiates one
//               btn_channel per button; optionally cancels movement while both
//               buttons of an adjacent pair (2k, 2k+1) are held.
//               Optional feature macro: OPPOSE_CANCEL_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_conditioner
    import shady_pong_pkg::*;
#(
    parameter int NUM_BTNS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16384,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    input  logic                frame_tick,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_move
);

    logic [NUM_BTNS-1:0] w_level;
    logic [NUM_BTNS-1:0] w_move;

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
        btn_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[gi]),
            .frame_tick  (frame_tick),
            .btn_level   (w_level[gi]),
            .btn_press   (btn_press[gi]),
            .btn_release (btn_release[gi]),
            .btn_move    (w_move[gi])
        );
    end

    assign btn_level = w_level;

`ifdef OPPOSE_CANCEL_EN
    if ((NUM_BTNS % 2) != 0) begin : g_odd_btns
        $error("btn_conditioner: OPPOSE_CANCEL_EN needs an even NUM_BTNS");
    end

    logic [NUM_BTNS-1:0] w_cancel;

    // Opposing buttons held together cancel; the channel timers keep running
    for (genvar gp = 0; gp < NUM_BTNS / 2; gp++) begin : g_pair
        assign w_cancel[2*gp]   = w_level[2*gp] & w_level[2*gp+1];
        assign w_cancel[2*gp+1] = w_level[2*gp] & w_level[2*gp+1];
    end

    assign btn_move = w_move & ~w_cancel;
`else
    assign btn_move = w_move;
`endif

endmodule

`default_nettype wire
